// File: rtl/uart_rx_deser_pkg.sv
// Shared UART receive definitions: default line parameters, receiver FSM state
// encoding and the majority-vote helper used by the bit sampler.
package uart_rx_deser_pkg;

    localparam int UART_CLK_DIV    = 4;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_WIDTH = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running clk divider with a synchronous clear
// so the sampling phase can be re-aligned to a start-bit edge.
module uart_baud_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0]   DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;

    always_comb begin
        if (clr_i || (div_q == DIV_LAST)) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick_o = !clr_i && (div_q == DIV_LAST);

endmodule

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive front end: synchronises rxd, oversamples with 3-point majority
// vote, deserialises LSB first and raises byte/overrun/framing status for the SFRs.
module uart_rx_deser
    import uart_rx_deser_pkg::*;
#(
    parameter int CLK_DIV    = UART_CLK_DIV,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rxd,
    input  logic                  rx_ack,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  rxd_int,
    output logic                  rx_full,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int            TW        = $clog2(OVERSAMPLE);
    localparam int            BW        = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_S2   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    logic                  rxd_meta_q, rxd_s_q, rxd_prev_q;
    logic [2:0]            state_q, state_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [1:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  rxd_int_q, rxd_int_d;
    logic                  rx_full_q, rx_full_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;

    logic tick, baud_clr, fall, maj, in_frame, vote, bit_end;

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (baud_clr),
        .tick_o (tick)
    );

    assign fall     = rxd_prev_q && !rxd_s_q;
    assign maj      = majority3(samp_q[0], samp_q[1], rxd_s_q);
    assign in_frame = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign vote     = in_frame && tick && (tick_cnt_q == TICK_S2);
    assign bit_end  = in_frame && tick && (tick_cnt_q == TICK_LAST);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        shreg_d     = shreg_q;
        r_data_d    = r_data_q;
        rxd_int_d   = 1'b0;
        frame_err_d = 1'b0;
        rx_full_d   = rx_full_q;
        overrun_d   = overrun_q;
        baud_clr    = 1'b0;

        if (rx_ack) begin
            rx_full_d = 1'b0;
            overrun_d = 1'b0;
        end

        if (in_frame && tick) begin
            tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
            if (tick_cnt_q == TICK_S0) samp_d[0] = rxd_s_q;
            if (tick_cnt_q == TICK_S1) samp_d[1] = rxd_s_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    baud_clr   = 1'b1;
                end
            end
            ST_START: begin
                if (vote && maj) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (vote) shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
                if (bit_end) begin
                    if (bit_cnt_q == BIT_LAST) state_d = ST_STOP;
                    else                       bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                // An ack landing with the accept refers to the old byte, so the new one still loads.
                if (vote) begin
                    if (!maj) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end else if (rx_full_q && !rx_ack) begin
                        overrun_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        r_data_d  = shreg_q;
                        rxd_int_d = 1'b1;
                        rx_full_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_BREAK: begin
                if (rxd_s_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the shift register is reset along with everything else; it is tiny and keeps outputs X-free.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_prev_q  <= 1'b1;
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            samp_q      <= '0;
            shreg_q     <= '0;
            r_data_q    <= '0;
            rxd_int_q   <= 1'b0;
            rx_full_q   <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
            rxd_prev_q  <= rxd_s_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_q      <= samp_d;
            shreg_q     <= shreg_d;
            r_data_q    <= r_data_d;
            rxd_int_q   <= rxd_int_d;
            rx_full_q   <= rx_full_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign r_data    = r_data_q;
    assign rxd_int   = rxd_int_q;
    assign rx_full   = rx_full_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: frame-level model of accept/overrun/framing outcomes
// checked every cycle, plus directed scenarios and randomized traffic.
`timescale 1ns/1ps
module tb_uart_rx_deser;

    localparam int CLK_DIV    = 4;
    localparam int OVERSAMPLE = 16;
    localparam int DW         = 8;
    localparam int BIT        = CLK_DIV * OVERSAMPLE;
    // Earliest cycle the decision for a frame may appear, counted from driving the start edge.
    localparam int LAT_MIN    = (DW + 1) * BIT + (OVERSAMPLE / 2 + 1) * CLK_DIV;
    localparam int LAT_MAX    = LAT_MIN + CLK_DIV + 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rxd = 1'b1;
    logic          rx_ack = 1'b0;
    logic [DW-1:0] r_data;
    logic          rxd_int, rx_full, frame_err, overrun;

    uart_rx_deser #(
        .CLK_DIV    (CLK_DIV),
        .OVERSAMPLE (OVERSAMPLE),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rxd       (rxd),
        .rx_ack    (rx_ack),
        .r_data    (r_data),
        .rxd_int   (rxd_int),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    typedef enum int {EV_UNDECIDED, EV_ACCEPT, EV_OVERRUN, EV_FERR} ev_kind_e;
    typedef struct {
        int            lo;
        int            hi;
        logic [DW-1:0] data;
        bit            stop_ok;
        ev_kind_e      kind;
    } frame_ev_t;

    frame_ev_t     evq[$];
    logic [DW-1:0] m_data = '0;
    bit            m_full = 1'b0;
    bit            m_ovr = 1'b0;
    bit            in_reset = 1'b1;
    int            int_count = 0;
    int            ferr_count = 0;
    int            last_int_cyc = 0;
    int            last_start = 0;

    // Frame outcome is decided by the model when the decision window opens.
    always @(negedge clk) begin : cmp
        logic [1:0] exp_p;
        if (!in_reset) begin
            if (rxd_int) begin
                int_count++;
                last_int_cyc = cyc;
            end
            if (frame_err) ferr_count++;

            if (evq.size() > 0 && cyc >= evq[0].lo) begin
                if (evq[0].kind == EV_UNDECIDED)
                    evq[0].kind = !evq[0].stop_ok ? EV_FERR : (m_full ? EV_OVERRUN : EV_ACCEPT);
                exp_p = (evq[0].kind == EV_ACCEPT) ? 2'b10 :
                        (evq[0].kind == EV_FERR)   ? 2'b01 : 2'b00;
                if (rxd_int || frame_err) begin
                    check("pulse_kind", 32'({rxd_int, frame_err}), 32'(exp_p));
                    if (evq[0].kind == EV_ACCEPT) begin
                        check("accept_data", 32'(r_data), 32'(evq[0].data));
                        m_data = evq[0].data;
                        m_full = 1'b1;
                    end
                    void'(evq.pop_front());
                end else if (cyc >= evq[0].hi) begin
                    check("missing_pulse", 32'(exp_p), 32'(0));
                    if (evq[0].kind == EV_OVERRUN) m_ovr = 1'b1;
                    void'(evq.pop_front());
                end
            end else begin
                check("quiet_outputs",
                      32'({r_data, rx_full, overrun, rxd_int, frame_err}),
                      32'({m_data, m_full, m_ovr, 2'b00}));
            end
        end
    end

    task automatic hold(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        hold(1);
        rx_ack = 1'b0;
        m_full = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // ack_bit < 0 means no ack; tail_low extends a bad stop bit into a break.
    task automatic send_frame(input logic [DW-1:0] d, input bit stop_ok,
                              input int ack_bit, input int tail_low);
        frame_ev_t ev;
        rxd        = 1'b0;
        ev.lo      = cyc + LAT_MIN;
        ev.hi      = cyc + LAT_MAX;
        ev.data    = d;
        ev.stop_ok = stop_ok;
        ev.kind    = EV_UNDECIDED;
        evq.push_back(ev);
        last_start = cyc;
        hold(BIT);
        for (int i = 0; i < DW; i++) begin
            rxd = d[i];
            if (i == ack_bit) begin
                do_ack();
                hold(BIT - 1);
            end else begin
                hold(BIT);
            end
        end
        rxd = stop_ok;
        hold(BIT);
        if (!stop_ok) begin
            hold(tail_low);
            rxd = 1'b1;
            hold(16);
        end
    endtask

    task automatic glitch(input int n);
        rxd = 1'b0;
        hold(n);
        rxd = 1'b1;
        hold(BIT + 16);
    endtask

    task automatic apply_reset(input int n);
        in_reset = 1'b1;
        reset    = 1'b0;
        hold(n);
        evq.delete();
        m_data   = '0;
        m_full   = 1'b0;
        m_ovr    = 1'b0;
        reset    = 1'b1;
        hold(1);
        in_reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int            i0, f0, r, ab, gap;
        logic [DW-1:0] d;
        bit            ok;

        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        hold(1);
        in_reset = 1'b0;
        check("reset_state", 32'({r_data, rx_full, overrun, rxd_int, frame_err}), 32'(0));
        hold(20);

        // 1: single frame
        i0 = int_count;
        send_frame(8'hA5, 1'b1, -1, 0);
        hold(8);
        check("t1_data", 32'(r_data), 32'h0000_00A5);
        check("t1_full", 32'(rx_full), 32'(1));
        check("t1_int_count", 32'(int_count - i0), 32'(1));
        check("t1_latency_in_range",
              32'((last_int_cyc - last_start >= 612) && (last_int_cyc - last_start <= 621)), 32'(1));

        // 2: back-to-back, ack during the second frame
        do_ack();
        i0 = int_count;
        send_frame(8'h3C, 1'b1, -1, 0);
        send_frame(8'hC3, 1'b1, 3, 0);
        hold(8);
        check("t2_int_count", 32'(int_count - i0), 32'(2));
        check("t2_data", 32'(r_data), 32'h0000_00C3);
        check("t2_overrun", 32'(overrun), 32'(0));

        // 3: overrun
        do_ack();
        i0 = int_count;
        send_frame(8'h11, 1'b1, -1, 0);
        hold(30);
        send_frame(8'h22, 1'b1, -1, 0);
        hold(8);
        check("t3_data", 32'(r_data), 32'h0000_0011);
        check("t3_overrun", 32'(overrun), 32'(1));
        check("t3_int_count", 32'(int_count - i0), 32'(1));
        do_ack();
        hold(2);
        check("t3_flags_cleared", 32'({rx_full, overrun}), 32'(0));

        // 4: short glitch is rejected
        i0 = int_count;
        f0 = ferr_count;
        glitch(20);
        check("t4_no_pulses", 32'((int_count - i0) + (ferr_count - f0)), 32'(0));
        check("t4_data", 32'(r_data), 32'h0000_0011);

        // 5: framing error into a break, then recovery
        i0 = int_count;
        f0 = ferr_count;
        send_frame(8'h55, 1'b0, -1, 200 - BIT);
        check("t5_ferr_count", 32'(ferr_count - f0), 32'(1));
        check("t5_data_kept", 32'(r_data), 32'h0000_0011);
        send_frame(8'h0F, 1'b1, -1, 0);
        hold(8);
        check("t5_next_data", 32'(r_data), 32'h0000_000F);
        check("t5_int_count", 32'(int_count - i0), 32'(1));

        // 6: reset in the middle of a frame
        rxd = 1'b0;
        hold(BIT);
        rxd = 1'b1;
        hold(3 * BIT);
        apply_reset(3);
        check("t6_reset_outputs", 32'({r_data, rx_full, overrun, rxd_int, frame_err}), 32'(0));
        hold(20);
        send_frame(8'h81, 1'b1, -1, 0);
        hold(8);
        check("t6_data", 32'(r_data), 32'h0000_0081);
        check("t6_full", 32'(rx_full), 32'(1));

        // Randomized traffic
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                glitch(int'($urandom_range(1, 24)));
            end else begin
                d  = DW'($urandom);
                ok = ($urandom_range(0, 5) != 0);
                ab = int'($urandom_range(0, 11));
                send_frame(d, ok, (ab < DW) ? ab : -1, ok ? 0 : int'($urandom_range(0, 150)));
                gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
                hold(gap);
            end
        end

        for (int k = 0; k < 2000 && evq.size() > 0; k++) hold(1);
        check("queue_drained", 32'(evq.size()), 32'(0));
        hold(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
